hid_key_events: RTL and testbench

Converts the byte stream of USB HID boot-protocol keyboard reports (8 bytes: modifier, reserved, six key slots) into discrete key-press events for the keyboard path of the serial terminal. It detects keys newly pressed relative to the previous report, suppresses duplicates and rollover reports, and generates typematic auto-repeat. It sits directly upstream of the scan-code-to-character mapper. `o_byte` and `o_mod` feed the mapper's `i_byte` and `i_mod`, and `o_valid` qualifies the mapper output.

---
 rtl/hid_key_events.sv | 205 ++++++++++++++++++++
 tb/tb_hid_key_events.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_key_events.sv
// hid_key_events: turns HID boot-protocol keyboard reports into key-press
// events with duplicate/rollover filtering and typematic auto-repeat.
module hid_key_events #(
    parameter int unsigned DELAY_CYC = 12_500_000,
    parameter int unsigned RATE_CYC  = 1_250_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    input  logic       i_sof,
    output logic [7:0] o_byte,
    output logic [7:0] o_mod,
    output logic       o_valid,
    output logic       o_repeat
);

    localparam logic [31:0] DELAY_LD = 32'(DELAY_CYC);
    localparam logic [31:0] RATE_LD  = 32'(RATE_CYC);
    localparam logic [7:0]  KEY_NONE = 8'h00;
    localparam logic [7:0]  KEY_ERR  = 8'h01;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_COMMIT,
        S_SCAN
    } state_t;

    state_t state;
    state_t state_n;

    // report being assembled; the reserved byte 1 is counted, not kept
    logic [3:0]  count;
    logic [7:0]  mod_in;
    logic [7:0]  keys_in [6];

    // committed report and the one before it
    logic [7:0]  snap [6];
    logic [7:0]  prev [6];
    logic [2:0]  slot;

    logic        rpt_active;
    logic [7:0]  rpt_key;
    logic [31:0] rpt_cnt;

    logic        store;
    logic        complete;
    logic        rollover;
    logic        last_slot;
    logic [7:0]  cur;
    logic        in_prev;
    logic        dup_earlier;
    logic        key_kept;
    logic        is_new;

    assign store     = i_valid && !i_sof
                       && count != 4'd0 && count != 4'd8;
    assign complete  = store && count == 4'd7;
    assign last_slot = slot == 3'd5;

    // Byte assembly; a start-of-frame byte always restarts the report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count  <= '0;
            mod_in <= '0;
            for (int i = 0; i < 6; i++) begin
                keys_in[i] <= '0;
            end
        end else if (i_valid && i_sof) begin
            mod_in <= i_byte;
            count  <= 4'd1;
        end else if (store) begin
            if (count >= 4'd2) begin
                keys_in[count[2:0] - 3'd2] <= i_byte;
            end
            count <= count + 4'd1;
        end
    end

    // A report carrying ErrorRollOver in any key slot is discarded.
    always_comb begin
        rollover = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (keys_in[i] == KEY_ERR) begin
                rollover = 1'b1;
            end
        end
    end

    // New-press test for the slot under scan, plus repeat-key presence.
    always_comb begin
        cur         = KEY_NONE;
        in_prev     = 1'b0;
        dup_earlier = 1'b0;
        key_kept    = 1'b0;
        if (slot < 3'd6) begin
            cur = snap[slot];
        end
        for (int j = 0; j < 6; j++) begin
            if (prev[j] == cur) begin
                in_prev = 1'b1;
            end
            if (3'(j) < slot && snap[j] == cur) begin
                dup_earlier = 1'b1;
            end
            if (snap[j] == rpt_key) begin
                key_kept = 1'b1;
            end
        end
        is_new = state == S_SCAN && cur != KEY_NONE
                 && !in_prev && !dup_earlier;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_n;
        end
    end

    // Next state: collect, one commit cycle, then six scan cycles.
    always_comb begin
        state_n = state;
        unique case (state)
            S_COLLECT: begin
                if (complete) begin
                    state_n = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_n = rollover ? S_COLLECT : S_SCAN;
            end
            S_SCAN: begin
                if (last_slot) begin
                    state_n = S_COLLECT;
                end
            end
            default: begin
                state_n = S_COLLECT;
            end
        endcase
    end

    // Commit snapshot and modifier, walk the slots, then age into prev.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mod <= '0;
            slot  <= '0;
            for (int i = 0; i < 6; i++) begin
                snap[i] <= '0;
                prev[i] <= '0;
            end
        end else begin
            if (state == S_COMMIT) begin
                slot <= '0;
                if (!rollover) begin
                    o_mod <= mod_in;
                    snap  <= keys_in;
                end
            end
            if (state == S_SCAN) begin
                slot <= last_slot ? 3'd0 : slot + 3'd1;
                if (last_slot) begin
                    prev <= snap;
                end
            end
        end
    end

    // Event strobe and typematic engine; counter only runs while collecting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_byte     <= '0;
            o_repeat   <= 1'b0;
            rpt_active <= 1'b0;
            rpt_key    <= '0;
            rpt_cnt    <= '0;
        end else begin
            o_valid <= 1'b0;
            if (is_new) begin
                o_valid    <= 1'b1;
                o_byte     <= cur;
                o_repeat   <= 1'b0;
                rpt_key    <= cur;
                rpt_active <= 1'b1;
                rpt_cnt    <= DELAY_LD;
            end else if (state == S_SCAN && last_slot && !key_kept) begin
                rpt_active <= 1'b0;
            end else if (state == S_COLLECT && rpt_active) begin
                if (rpt_cnt == 32'd1) begin
                    o_valid  <= 1'b1;
                    o_byte   <= rpt_key;
                    o_repeat <= 1'b1;
                    rpt_cnt  <= RATE_LD;
                end else begin
                    rpt_cnt <= rpt_cnt - 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hid_key_events.sv
// tb_hid_key_events: directed and randomized check of hid_key_events
// against a report-level behavioural model.
`timescale 1ns/1ps
module tb_hid_key_events;

    localparam int DELAY = 20;
    localparam int RATE  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] o_byte;
    logic [7:0] o_mod;
    logic       o_valid;
    logic       o_repeat;

    hid_key_events #(
        .DELAY_CYC(DELAY),
        .RATE_CYC (RATE)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_byte  (in_byte),
        .i_valid (in_valid),
        .i_sof   (in_sof),
        .o_byte  (o_byte),
        .o_mod   (o_mod),
        .o_valid (o_valid),
        .o_repeat(o_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         ed = 0;
    bit         started = 1'b0;
    logic [7:0] q[$];
    logic [7:0] m_prev[6];
    bit         m_active = 1'b0;
    logic [7:0] m_key = 8'h00;
    int         m_rem = 0;
    int         last_p = -100;
    int         last_span = 0;
    logic [7:0] ev_byte[int];
    bit         ev_rep[int];
    logic [7:0] mod_now = 8'h00;
    logic [7:0] mod_pend = 8'h00;
    int         mod_edge = -1;
    bit         x_valid = 1'b0;
    logic [7:0] x_byte = 8'h00;
    bit         x_rep = 1'b0;

    // A report finished at edge p: schedule its press events.
    function automatic void model_report(input int p);
        logic [7:0] keys[6];
        bit roll;
        bit any;
        bit seen;
        bit kept;
        roll = 1'b0;
        any  = 1'b0;
        kept = 1'b0;
        for (int i = 0; i < 6; i++) begin
            keys[i] = q[i + 2];
            if (keys[i] == 8'h01) roll = 1'b1;
        end
        last_p = p;
        if (roll) begin
            last_span = 1;
            return;
        end
        last_span = 7;
        mod_pend  = q[0];
        mod_edge  = p + 1;
        for (int k = 0; k < 6; k++) begin
            seen = keys[k] == 8'h00;
            for (int j = 0; j < 6; j++)
                if (m_prev[j] == keys[k]) seen = 1'b1;
            for (int j = 0; j < k; j++)
                if (keys[j] == keys[k]) seen = 1'b1;
            if (!seen) begin
                ev_byte[p + 2 + k] = keys[k];
                ev_rep[p + 2 + k]  = 1'b0;
                m_key = keys[k];
                any = 1'b1;
            end
        end
        for (int j = 0; j < 6; j++)
            if (keys[j] == m_key) kept = 1'b1;
        if (any) begin
            m_active = 1'b1;
            m_rem    = DELAY;
        end else if (!kept) begin
            m_active = 1'b0;
        end
        m_prev = keys;
    endfunction

    always @(posedge clk) begin
        bit paused;
        ed++;
        if (rst) begin
            started = 1'b1;
            q.delete();
            for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
            m_active = 1'b0;
            m_key = 8'h00;
            m_rem = 0;
            last_p = -100;
            last_span = 0;
            ev_byte.delete();
            ev_rep.delete();
            mod_now = 8'h00;
            mod_edge = -1;
            x_valid = 1'b0;
            x_byte = 8'h00;
            x_rep = 1'b0;
        end else begin
            paused = ed > last_p && ed <= last_p + last_span;
            if (m_active && !paused) begin
                m_rem--;
                if (m_rem == 0) begin
                    ev_byte[ed] = m_key;
                    ev_rep[ed]  = 1'b1;
                    m_rem = RATE;
                end
            end
            if (in_valid) begin
                if (in_sof) begin
                    q.delete();
                    q.push_back(in_byte);
                end else if (q.size() >= 1 && q.size() <= 7) begin
                    q.push_back(in_byte);
                    if (q.size() == 8) model_report(ed);
                end
            end
            x_valid = 1'b0;
            if (ev_byte.exists(ed)) begin
                x_valid = 1'b1;
                x_byte  = ev_byte[ed];
                x_rep   = ev_rep[ed];
                ev_byte.delete(ed);
                ev_rep.delete(ed);
            end
            if (mod_edge == ed) mod_now = mod_pend;
        end
    end

    // ---------------- per-cycle compare ----------------
    int         ev_cnt = 0;
    logic [7:0] log_b[$];
    bit         log_r[$];

    always @(negedge clk) begin
        if (started) begin
            chk("o_valid", 32'(o_valid), 32'(x_valid));
            chk("o_byte", 32'(o_byte), 32'(x_byte));
            chk("o_repeat", 32'(o_repeat), 32'(x_rep));
            chk("o_mod", 32'(o_mod), 32'(mod_now));
            if (o_valid === 1'b1) begin
                ev_cnt++;
                log_b.push_back(o_byte);
                log_r.push_back(o_repeat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] b, input bit sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_byte  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_byte  = 8'($urandom);
        end
    endtask

    // Returns on the first falling edge after byte 7 is accepted.
    task automatic send(input logic [63:0] r);
        for (int i = 0; i < 8; i++) put(r[63 - 8 * i -: 8], i == 0);
        idle(1);
    endtask

    task automatic nexte(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [63:0] REP_A = 64'h00_00_04_00_00_00_00_00;
    localparam logic [63:0] REP_Z = 64'h00_00_00_00_00_00_00_00;

    initial begin
        int c0;
        logic [63:0] r;
        int pick;

        rst = 1'b1;
        idle(3);
        chk("rst_byte", 32'(o_byte), 32'h0);
        chk("rst_mod", 32'(o_mod), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_repeat", 32'(o_repeat), 32'h0);
        rst = 1'b0;
        idle(2);

        // first press at N+3, identical report is silent
        send(REP_A);
        nexte(1);
        chk("a_early", 32'(o_valid), 32'h0);
        nexte(1);
        chk("a_valid", 32'(o_valid), 32'h1);
        chk("a_byte", 32'(o_byte), 32'h04);
        chk("a_rep", 32'(o_repeat), 32'h0);
        #1 c0 = ev_cnt;
        send(REP_A);
        idle(8);
        #1 chk("a_dup_none", 32'(ev_cnt - c0), 32'h0);

        // second key in slot 1 at N+4 with modifier
        c0 = ev_cnt;
        send(64'h02_00_00_0B_04_00_00_00);
        nexte(2);
        chk("b_no_04", 32'(o_valid), 32'h0);
        nexte(1);
        chk("b_valid", 32'(o_valid), 32'h1);
        chk("b_byte", 32'(o_byte), 32'h0B);
        chk("b_mod", 32'(o_mod), 32'h02);
        idle(5);
        #1 chk("b_count", 32'(ev_cnt - c0), 32'h1);

        c0 = ev_cnt;
        send(REP_Z);
        idle(40);
        #1 chk("release_quiet", 32'(ev_cnt - c0), 32'h0);

        // slot-5 press: repeats at +20, +25, +30 after the press strobe
        send(64'h00_00_00_00_00_00_00_04);
        nexte(7);
        chk("t_press", 32'(o_valid), 32'h1);
        chk("t_press_rep", 32'(o_repeat), 32'h0);
        nexte(19);
        chk("t_pre_rep", 32'(o_valid), 32'h0);
        nexte(1);
        chk("t_rep1", 32'(o_valid), 32'h1);
        chk("t_rep1_flag", 32'(o_repeat), 32'h1);
        chk("t_rep1_byte", 32'(o_byte), 32'h04);
        nexte(5);
        chk("t_rep2", 32'(o_valid), 32'h1);
        nexte(5);
        chk("t_rep3", 32'(o_valid), 32'h1);
        send(REP_Z);
        idle(8);
        #1 c0 = ev_cnt;
        idle(40);
        #1 chk("t_stop", 32'(ev_cnt - c0), 32'h0);

        // rollover report keeps modifier and repeat
        send(64'h20_00_04_00_00_00_00_00);
        idle(3);
        #1 c0 = ev_cnt;
        send(64'h00_00_01_01_01_01_01_01);
        idle(8);
        chk("roll_mod", 32'(o_mod), 32'h20);
        #1 chk("roll_silent", 32'(ev_cnt - c0), 32'h0);
        idle(40);
        #1 chk("roll_repeats", 32'(ev_cnt > c0), 32'h1);
        chk("roll_rep_byte", 32'(log_b[$]), 32'h04);
        chk("roll_rep_flag", 32'(log_r[$]), 32'h1);

        // duplicate slots: two events, last becomes repeat key
        send(REP_Z);
        idle(8);
        #1 c0 = ev_cnt;
        send(64'h00_00_05_05_06_00_00_00);
        idle(8);
        #1 chk("dup_count", 32'(ev_cnt - c0), 32'h2);
        chk("dup_first", 32'(log_b[$ - 1]), 32'h05);
        chk("dup_second", 32'(log_b[$]), 32'h06);
        idle(30);
        chk("dup_rep_key", 32'(log_b[$]), 32'h06);
        chk("dup_rep_flag", 32'(log_r[$]), 32'h1);

        // partial report discarded by a fresh start-of-frame
        send(REP_Z);
        idle(8);
        #1 c0 = ev_cnt;
        put(8'h00, 1'b1);
        put(8'h00, 1'b0);
        put(8'h07, 1'b0);
        put(8'h00, 1'b0);
        send(64'h00_00_07_00_00_00_00_00);
        idle(8);
        #1 chk("sof_count", 32'(ev_cnt - c0), 32'h1);
        chk("sof_byte", 32'(log_b[$]), 32'h07);

        // reset in the middle of a scan
        send(REP_Z);
        idle(8);
        #1 c0 = ev_cnt;
        send(64'h00_00_00_00_00_00_0C_0D);
        nexte(2);
        rst = 1'b1;
        nexte(1);
        chk("mrst_byte", 32'(o_byte), 32'h0);
        chk("mrst_mod", 32'(o_mod), 32'h0);
        chk("mrst_valid", 32'(o_valid), 32'h0);
        chk("mrst_repeat", 32'(o_repeat), 32'h0);
        rst = 1'b0;
        idle(40);
        #1 chk("mrst_quiet", 32'(ev_cnt - c0), 32'h0);

        // randomized reports with gaps, strays and restarts
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) put(8'($urandom), 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                pick = $urandom_range(1, 6);
                for (int i = 0; i < pick; i++) put(8'($urandom), i == 0);
            end
            r[63:56] = 8'($urandom);
            r[55:48] = 8'($urandom);
            for (int s = 0; s < 6; s++) begin
                pick = $urandom_range(0, 99);
                if (pick < 45)
                    r[47 - 8 * s -: 8] = 8'h00;
                else if (pick < 48)
                    r[47 - 8 * s -: 8] = 8'h01;
                else
                    r[47 - 8 * s -: 8] = 8'($urandom_range(4, 9));
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
                put(r[63 - 8 * i -: 8], i == 0);
            end
            idle($urandom_range(1, 30));
        end
        idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
